// File: rtl/bullet_engine_if.sv
// Frame, fire, query and status signals between the bullet engine and its neighbours.
// The master drives the controls and queries; the slave (the engine) drives the results.
interface bullet_engine_if;
  logic       frame_tick;
  logic       fire;
  logic [7:0] user_x;
  logic [7:0] enemy_x;
  logic [7:0] q_x;
  logic [6:0] q_y;
  logic       bullet_here;
  logic       hit;
  logic [7:0] score;
  logic       busy;
  logic [3:0] active_count;
  logic       overrun;

  modport master (
    output frame_tick, fire, user_x, enemy_x, q_x, q_y,
    input  bullet_here, hit, score, busy, active_count, overrun
  );

  modport slave (
    input  frame_tick, fire, user_x, enemy_x, q_x, q_y,
    output bullet_here, hit, score, busy, active_count, overrun
  );
endinterface

// File: rtl/bullet_engine.sv
// Player bullet table: spawns on fire, sweeps one slot per cycle per frame, scores enemy hits.
// Queries answer 1 cycle later; a sweep lasts MAX_BULLETS cycles; no backpressure, ticks during a sweep are dropped and flagged.
module bullet_engine #(
  parameter int MAX_BULLETS = 8,
  parameter int USER_Y      = 110,
  parameter int ENEMY_Y     = 10,
  parameter int HIT_W       = 2,
  parameter int COOLDOWN    = 4
) (
  input logic             clk,
  input logic             resetn,
  bullet_engine_if.slave  eng
);

  localparam int IDX_W = (MAX_BULLETS > 1) ? $clog2(MAX_BULLETS) : 1;
  localparam logic [6:0]       SPAWN_Y   = 7'(USER_Y - 1);
  localparam logic [6:0]       ENEMY_ROW = 7'(ENEMY_Y);
  localparam logic [7:0]       CD_LOAD   = 8'(COOLDOWN);
  localparam logic [8:0]       HIT_LIM   = 9'(HIT_W);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MAX_BULLETS - 1);

  typedef struct packed {
    logic       valid;
    logic [7:0] x;
    logic [6:0] y;
  } slot_t;

  typedef enum logic {IDLE, UPDATE} state_t;

  slot_t            slots [MAX_BULLETS];
  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       cooldown;
  logic             fire_prev;
  logic             fire_pending;
  logic             bullet_here_r;
  logic             hit_r;
  logic [7:0]       score_r;
  logic             busy_r;
  logic [3:0]       active_count_r;
  logic             overrun_r;

  logic             fire_rise;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [4:0]       pop;
  logic             q_match;
  slot_t            cur;
  logic signed [8:0] diff;
  logic [8:0]       abs_diff;
  logic             cur_hit;

  assign fire_rise = eng.fire & ~fire_prev;

  // Descending scan so the lowest-index free slot is the one left standing.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
      if (!slots[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    pop     = '0;
    q_match = 1'b0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      pop     = pop + 5'(slots[i].valid);
      q_match = q_match | (slots[i].valid & (slots[i].x == eng.q_x) & (slots[i].y == eng.q_y));
    end
  end

  // Hit window is symmetric around the enemy column, evaluated against the live enemy position.
  always_comb begin
    cur      = slots[idx];
    diff     = $signed({1'b0, cur.x}) - $signed({1'b0, eng.enemy_x});
    abs_diff = diff[8] ? 9'(-diff) : 9'(diff);
    cur_hit  = cur.valid && (cur.y == ENEMY_ROW) && (abs_diff <= HIT_LIM);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_BULLETS; i++) begin
        slots[i] <= '0;
      end
      state          <= IDLE;
      idx            <= '0;
      cooldown       <= '0;
      fire_prev      <= 1'b0;
      fire_pending   <= 1'b0;
      bullet_here_r  <= 1'b0;
      hit_r          <= 1'b0;
      score_r        <= '0;
      busy_r         <= 1'b0;
      active_count_r <= '0;
      overrun_r      <= 1'b0;
    end else begin
      fire_prev      <= eng.fire;
      bullet_here_r  <= q_match;
      active_count_r <= (pop > 5'd15) ? 4'hF : pop[3:0];
      hit_r          <= 1'b0;
      overrun_r      <= 1'b0;

      case (state)
        IDLE: begin
          if (eng.frame_tick) begin
            state  <= UPDATE;
            idx    <= '0;
            busy_r <= 1'b1;
            if (cooldown != 8'd0) cooldown <= cooldown - 8'd1;
          end else if (fire_pending) begin
            fire_pending <= 1'b0;
            if (cooldown == 8'd0 && free_found) begin
              slots[free_idx] <= '{valid: 1'b1, x: eng.user_x, y: SPAWN_Y};
              cooldown        <= CD_LOAD;
            end
          end
        end

        UPDATE: begin
          overrun_r <= eng.frame_tick;
          if (cur.valid) begin
            if (cur_hit) begin
              slots[idx].valid <= 1'b0;
              hit_r            <= 1'b1;
              if (score_r != 8'hFF) score_r <= score_r + 8'd1;
            end else if (cur.y == 7'd0) begin
              slots[idx].valid <= 1'b0;
            end else begin
              slots[idx].y <= cur.y - 7'd1;
            end
          end
          if (idx == LAST_IDX) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        default: state <= IDLE;
      endcase

      // A rise in the same cycle as a spawn or drop re-arms the request.
      if (fire_rise) fire_pending <= 1'b1;
    end
  end

  assign eng.bullet_here  = bullet_here_r;
  assign eng.hit          = hit_r;
  assign eng.score        = score_r;
  assign eng.busy         = busy_r;
  assign eng.active_count = active_count_r;
  assign eng.overrun      = overrun_r;

endmodule
